// File: rtl/bit_population_counter_pkg.sv
//==============================================================================
// Module      : bit_population_counter_pkg
// Description : Shared types and width helper for the streaming population
//               counter (count mode enum, per-beat count width function).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bit_population_counter_pkg;

  // Per-beat selection of which bit value is being counted
  typedef enum logic {
    CNT_ONES  = 1'b0,
    CNT_ZEROS = 1'b1
  } count_mode_t;

  // Width needed to hold a count of 0..width inclusive
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage : bit_population_counter_pkg

`default_nettype wire

// File: rtl/bit_population_counter_stage.sv
//==============================================================================
// Module      : bit_population_counter_stage
// Description : One enabled pipeline stage. Adds the popcount of its own
//               STAGE_BITS-wide slice (inverted in zero-count mode) to the
//               carried count and forwards the beat sideband.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bit_population_counter_stage
  import bit_population_counter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGE_BITS = 8,
  parameter int CNT_W      = 6,
  parameter int STAGE_IDX  = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  input  count_mode_t      mode_i,
  input  logic             last_i,
  input  logic             val_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [WIDTH-1:0] data_o,
  output count_mode_t      mode_o,
  output logic             last_o,
  output logic             val_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [STAGE_BITS-1:0] w_slice;
  logic [CNT_W-1:0]      w_pop;

  logic [WIDTH-1:0]      r_data;
  count_mode_t           r_mode;
  logic                  r_last;
  logic                  r_val;
  logic [CNT_W-1:0]      r_cnt;

  // Counting zeros is counting ones of the inverted slice
  assign w_slice = data_i[STAGE_IDX*STAGE_BITS +: STAGE_BITS]
                 ^ {STAGE_BITS{mode_i == CNT_ZEROS}};

  // Popcount of this stage's slice
  always_comb begin
    w_pop = '0;
    for (int b = 0; b < STAGE_BITS; b++) begin
      w_pop = w_pop + CNT_W'(w_slice[b]);
    end
  end

  // Stage register, frozen while the pipeline is stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data <= '0;
      r_mode <= CNT_ONES;
      r_last <= 1'b0;
      r_val  <= 1'b0;
      r_cnt  <= '0;
    end else if (en_i) begin
      r_data <= data_i;
      r_mode <= mode_i;
      r_last <= last_i;
      r_val  <= val_i;
      r_cnt  <= cnt_i + w_pop;
    end
  end

  assign data_o = r_data;
  assign mode_o = r_mode;
  assign last_o = r_last;
  assign val_o  = r_val;
  assign cnt_o  = r_cnt;

endmodule : bit_population_counter_stage

`default_nettype wire

// File: rtl/bit_population_counter_stream.sv
//==============================================================================
// Module      : bit_population_counter_stream
// Description : Streaming per-beat population counter with a saturating
//               per-packet running total. Input register, STAGES slice-adding
//               stages and an output/accumulate stage, all sharing one
//               stall enable.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bit_population_counter_stream
  import bit_population_counter_pkg::*;
#(
  parameter int  WIDTH      = 32,
  parameter int  STAGE_BITS = 8,
  parameter int  ACC_W      = 16,
  localparam int CNT_W      = cnt_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_mode_i,
  input  logic             data_last_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [CNT_W-1:0] data_o,
  output logic [ACC_W-1:0] total_o,
  output logic             total_ovf_o,
  output logic             data_last_o,
  output logic             data_val_o,
  input  logic             data_ready_i
);

  localparam int STAGES = (STAGE_BITS > 0) ? (WIDTH / STAGE_BITS) : 1;
  localparam int c_rem  = (STAGE_BITS > 0) ? (WIDTH % STAGE_BITS) : 0;
  localparam logic [ACC_W-1:0] c_acc_max = '1;

  // Reject parameter sets the datapath cannot represent
  if (STAGE_BITS == 0) begin : g_chk_stage_bits
    $error("STAGE_BITS must be non-zero");
  end
  if (c_rem != 0) begin : g_chk_divisible
    $error("WIDTH must be a multiple of STAGE_BITS");
  end
  if (ACC_W < CNT_W) begin : g_chk_acc_w
    $error("ACC_W must be at least CNT_W");
  end

  logic             w_en;
  logic             w_hs;

  logic [WIDTH-1:0] r_in_data;
  count_mode_t      r_in_mode;
  logic             r_in_last;
  logic             r_in_val;

  logic [WIDTH-1:0] w_data [STAGES+1];
  count_mode_t      w_mode [STAGES+1];
  logic             w_last [STAGES+1];
  logic             w_val  [STAGES+1];
  logic [CNT_W-1:0] w_cnt  [STAGES+1];

  logic [ACC_W-1:0] r_acc;
  logic             r_acc_ovf;
  logic [ACC_W-1:0] w_acc_base;
  logic             w_ovf_base;
  logic [ACC_W:0]   w_sum;
  logic             w_sat;
  logic [ACC_W-1:0] w_total;

  logic             r_out_val;
  logic             r_out_last;
  logic [CNT_W-1:0] r_out_cnt;
  logic [ACC_W-1:0] r_total;
  logic             r_ovf;

  logic             w_unused_tail;

  // Everything advances unless a valid output is being held by downstream
  assign w_en         = !r_out_val || data_ready_i;
  assign data_ready_o = w_en;
  assign w_hs         = r_out_val && data_ready_i;

  // Input register: a beat is captured exactly when it is accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_data <= '0;
      r_in_mode <= CNT_ONES;
      r_in_last <= 1'b0;
      r_in_val  <= 1'b0;
    end else if (w_en) begin
      r_in_data <= data_i;
      r_in_mode <= count_mode_t'(data_mode_i);
      r_in_last <= data_last_i;
      r_in_val  <= data_val_i;
    end
  end

  assign w_data[0] = r_in_data;
  assign w_mode[0] = r_in_mode;
  assign w_last[0] = r_in_last;
  assign w_val[0]  = r_in_val;
  assign w_cnt[0]  = '0;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    bit_population_counter_stage #(
      .WIDTH      (WIDTH),
      .STAGE_BITS (STAGE_BITS),
      .CNT_W      (CNT_W),
      .STAGE_IDX  (g)
    ) u_stage (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (w_en),
      .data_i (w_data[g]),
      .mode_i (w_mode[g]),
      .last_i (w_last[g]),
      .val_i  (w_val[g]),
      .cnt_i  (w_cnt[g]),
      .data_o (w_data[g+1]),
      .mode_o (w_mode[g+1]),
      .last_o (w_last[g+1]),
      .val_o  (w_val[g+1]),
      .cnt_o  (w_cnt[g+1])
    );
  end

  // The word and mode are fully consumed by the last stage
  assign w_unused_tail = ^{w_data[STAGES], w_mode[STAGES]};

  // Accumulator as it stands after the handshake on this edge (if any), so a
  // beat entering the output register sees its predecessor's total.
  always_comb begin
    w_acc_base = r_acc;
    w_ovf_base = r_acc_ovf;
    if (w_hs) begin
      w_acc_base = r_out_last ? '0 : r_total;
      w_ovf_base = !r_out_last && r_ovf;
    end
    w_sum   = {1'b0, w_acc_base} + {{(ACC_W+1-CNT_W){1'b0}}, w_cnt[STAGES]};
    w_sat   = w_sum[ACC_W];
    w_total = w_sat ? c_acc_max : w_sum[ACC_W-1:0];
  end

  // Accumulator only moves on an output handshake (base equals r_acc otherwise)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
    end else begin
      r_acc     <= w_acc_base;
      r_acc_ovf <= w_ovf_base;
    end
  end

  // Output register: per-beat count and saturating packet total
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_val  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_cnt  <= '0;
      r_total    <= '0;
      r_ovf      <= 1'b0;
    end else if (w_en) begin
      r_out_val <= w_val[STAGES];
      if (w_val[STAGES]) begin
        r_out_last <= w_last[STAGES];
        r_out_cnt  <= w_cnt[STAGES];
        r_total    <= w_total;
        r_ovf      <= w_ovf_base || w_sat;
      end
    end
  end

  assign data_o      = r_out_cnt;
  assign total_o     = r_total;
  assign total_ovf_o = r_ovf;
  assign data_last_o = r_out_last;
  assign data_val_o  = r_out_val;

endmodule : bit_population_counter_stream

`default_nettype wire
